// File: rtl/oram_requester.sv
// Host-side requester for the ORAM core: buffers commands, issues each as a
// single-cycle input_ready strobe, and returns one response per command.
module oram_requester #(
  parameter int D          = 8,
  parameter int A          = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [D-1:0]     cmd_addr,
  input  logic [8*A-1:0]   cmd_wdata,
  output logic [D-1:0]     rw_block_number,
  output logic [8*A-1:0]   w_value,
  output logic             rw_indicator,
  output logic             input_ready,
  input  logic [8*A-1:0]   r_value,
  input  logic             output_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_write,
  output logic [D-1:0]     rsp_addr,
  output logic [8*A-1:0]   rsp_rdata,
  output logic             rsp_timeout,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshakes: a command transfers on a clock edge where cmd_valid && cmd_ready;
  // a response transfers on an edge where rsp_valid && rsp_ready, and rsp_*
  // hold stable while rsp_valid && !rsp_ready.

  localparam int W  = 8 * A;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic          fifo_write [FIFO_DEPTH];
  logic [D-1:0]  fifo_addr  [FIFO_DEPTH];
  logic [W-1:0]  fifo_data  [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign busy      = !empty || (state != S_IDLE);
  assign state_dbg = state;
  assign timer_inc = timer + TW'(1);

  // Storage array needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write[wr_ptr] <= cmd_write;
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_data[wr_ptr]  <= cmd_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      timer           <= '0;
      input_ready     <= 1'b0;
      rw_block_number <= '0;
      w_value         <= '0;
      rw_indicator    <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_write       <= 1'b0;
      rsp_addr        <= '0;
      rsp_rdata       <= '0;
      rsp_timeout     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            rw_block_number <= fifo_addr[rd_ptr];
            w_value         <= fifo_data[rd_ptr];
            rw_indicator    <= fifo_write[rd_ptr];
            input_ready     <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          input_ready <= 1'b0;
          timer       <= '0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          // output_ready is a level: the core leaves it high between operations.
          if (output_ready) begin
            rsp_write   <= rw_indicator;
            rsp_addr    <= rw_block_number;
            rsp_rdata   <= rw_indicator ? '0 : r_value;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else begin
            timer <= timer_inc;
            if (timer_inc == TW'(TIMEOUT)) begin
              rsp_write   <= rw_indicator;
              rsp_addr    <= rw_block_number;
              rsp_rdata   <= '0;
              rsp_timeout <= 1'b1;
              rsp_valid   <= 1'b1;
              state       <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oram_requester.sv
// Bench for oram_requester: table of commands, ORAM behavioural model,
// response scoreboard and hand-written multi-cycle corner cases.
module tb_oram_requester;

  localparam int D          = 8;
  localparam int A          = 4;
  localparam int W          = 8 * A;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 3;
  localparam int RW         = 2 + D + W;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [D-1:0] cmd_addr;
  logic [W-1:0] cmd_wdata;
  logic [D-1:0] rw_block_number;
  logic [W-1:0] w_value;
  logic         rw_indicator;
  logic         input_ready;
  logic [W-1:0] r_value;
  logic         output_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_write;
  logic [D-1:0] rsp_addr;
  logic [W-1:0] rsp_rdata;
  logic         rsp_timeout;
  logic         busy;
  logic [1:0]   state_dbg;

  oram_requester #(
    .D(D), .A(A), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rw_block_number(rw_block_number), .w_value(w_value),
    .rw_indicator(rw_indicator), .input_ready(input_ready),
    .r_value(r_value), .output_ready(output_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .busy(busy), .state_dbg(state_dbg)
  );

  typedef struct {
    logic         w;
    logic [D-1:0] a;
    logic [W-1:0] d;
    logic [W-1:0] exp_rd;
  } vec_t;

  vec_t         tbl [8];
  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] exp_v;
  logic [RW-1:0] got_v;
  logic [W-1:0] oram_mem [256];
  logic [W-1:0] ref_mem  [256];
  logic [D-1:0] rd_addrs [4];
  logic         oram_stall;
  logic         ir_prev;
  int           checks;
  int           errors;
  int           cyc;
  int           accept_cyc;
  int           ir_pulses;
  int           ir_double;
  int           rsp_count;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ORAM model ----------------
  assign output_ready = !oram_stall;
  always @(posedge clk) begin
    if (input_ready) begin
      if (rw_indicator) oram_mem[rw_block_number] <= w_value;
      else              r_value <= oram_mem[rw_block_number];
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (input_ready) begin
        ir_pulses++;
        if (ir_prev) ir_double++;
      end
      ir_prev = input_ready;
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        checks++;
        got_v = {rsp_timeout, rsp_write, rsp_addr, rsp_rdata};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got %h", got_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (got_v !== exp_v) begin
            errors++;
            $display("FAIL rsp_data got {to,wr,addr,data}=%h exp %h", got_v, exp_v);
          end
        end
      end
    end else begin
      ir_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic w, input logic [D-1:0] a, input logic [W-1:0] d,
                      input logic [W-1:0] exp_rd, input logic exp_to);
    int budget;
    budget = 50;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_accept got cmd_ready=0 exp 1 addr %0h", a);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back({exp_to, w, a, exp_rd});
    if (w) ref_mem[a] = d;
    @(negedge clk);
    accept_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 200;
    while ((busy || rsp_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("wait_idle_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_rsp_valid(output int at_cyc);
    int budget;
    budget = 50;
    while (!rsp_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_rsp_valid got 0 exp 1");
    end
    at_cyc = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_input_ready"}, {63'd0, input_ready}, 64'd0);
    chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    chk({tag, "_rsp_fields"}, {30'd0, rsp_timeout, rsp_write, rsp_addr, rsp_rdata}, 64'd0);
    chk({tag, "_req_fields"}, {23'd0, rw_indicator, rw_block_number, w_value}, 64'd0);
    chk({tag, "_state"}, {62'd0, state_dbg}, 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c_a;
    int c_b;
    int base;
    int seen_ir;
    int seen_rv;
    logic [D-1:0] ra;

    checks = 0; errors = 0; cyc = 0; accept_cyc = 0;
    ir_pulses = 0; ir_double = 0; rsp_count = 0; ir_prev = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; oram_stall = 1'b0; r_value = '0;
    for (int i = 0; i < 256; i++) begin
      oram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    rd_addrs[0] = 8'h05; rd_addrs[1] = 8'h10; rd_addrs[2] = 8'h11; rd_addrs[3] = 8'h20;
    tbl[0] = '{1'b1, 8'h10, 32'h12345678, 32'h0};
    tbl[1] = '{1'b1, 8'h11, 32'hA5A5A5A5, 32'h0};
    tbl[2] = '{1'b0, 8'h10, 32'h0,        32'h12345678};
    tbl[3] = '{1'b0, 8'h11, 32'h0,        32'hA5A5A5A5};
    tbl[4] = '{1'b1, 8'h10, 32'h00000001, 32'h0};
    tbl[5] = '{1'b0, 8'h10, 32'h0,        32'h00000001};
    tbl[6] = '{1'b0, 8'h05, 32'h0,        32'hDEADBEEF};
    tbl[7] = '{1'b0, 8'h20, 32'h0,        32'h0};

    // Reset asserted between clock edges
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset_init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Write then read with latency measurement
    rsp_ready = 1'b1;
    send(1'b1, 8'h05, 32'hDEADBEEF, 32'h0, 1'b0);
    wait_idle();
    send(1'b0, 8'h05, 32'h0, 32'hDEADBEEF, 1'b0);
    c_a = accept_cyc;
    wait_rsp_valid(c_b);
    chk("read_latency", 64'(c_b - c_a), 64'd3);
    chk("read_addr", {56'd0, rsp_addr}, 64'h05);
    chk("read_data", {32'd0, rsp_rdata}, 64'hDEADBEEF);
    wait_idle();

    // Table of commands, back to back
    for (int i = 0; i < 8; i++) send(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_rd, 1'b0);
    wait_idle();

    // Eight back-to-back reads: single-cycle strobe and ordering
    ir_pulses = 0;
    ir_double = 0;
    base = rsp_count;
    for (int i = 0; i < 8; i++) begin
      ra = rd_addrs[$urandom_range(0, 3)];
      send(1'b0, ra, 32'h0, ref_mem[ra], 1'b0);
    end
    wait_idle();
    chk("strobe_pulses", 64'(ir_pulses), 64'd8);
    chk("strobe_responses", 64'(rsp_count - base), 64'd8);
    chk("strobe_double", 64'(ir_double), 64'd0);

    // FIFO full with one in flight, then drain across pointer wrap
    rsp_ready = 1'b0;
    base = rsp_count;
    send(1'b1, 8'h30, 32'h11111111, 32'h0, 1'b0);
    send(1'b1, 8'h31, 32'h22222222, 32'h0, 1'b0);
    send(1'b0, 8'h30, 32'h0, 32'h11111111, 1'b0);
    send(1'b0, 8'h31, 32'h0, 32'h22222222, 1'b0);
    send(1'b1, 8'h32, 32'h33333333, 32'h0, 1'b0);
    chk("full_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("full_busy", {63'd0, busy}, 64'd1);
    chk("full_state_resp", {62'd0, state_dbg}, 64'd3);
    repeat (3) @(negedge clk);
    chk("full_hold_rsp_addr", {56'd0, rsp_addr}, 64'h30);
    chk("full_hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    rsp_ready = 1'b1;
    wait_idle();
    chk("full_drain_count", 64'(rsp_count - base), 64'd5);

    // Timeout: ORAM never completes
    oram_stall = 1'b1;
    send(1'b0, 8'h05, 32'h0, 32'h0, 1'b1);
    c_a = 0;
    for (int i = 0; i < 10 && !input_ready; i++) @(negedge clk);
    chk("timeout_issue_seen", {63'd0, input_ready}, 64'd1);
    c_a = cyc;
    wait_rsp_valid(c_b);
    chk("timeout_latency", 64'(c_b - c_a), 64'd4);
    chk("timeout_flag", {63'd0, rsp_timeout}, 64'd1);
    chk("timeout_rdata", {32'd0, rsp_rdata}, 64'd0);
    wait_idle();
    oram_stall = 1'b0;

    // Asynchronous reset while a response is held
    rsp_ready = 1'b0;
    send(1'b0, 8'h10, 32'h0, ref_mem[8'h10], 1'b0);
    wait_rsp_valid(c_b);
    chk("held_rsp_addr", {56'd0, rsp_addr}, 64'h10);
    #3 rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;

    // Reset during WAIT with two commands queued
    oram_stall = 1'b1;
    send(1'b0, 8'h10, 32'h0, 32'h0, 1'b1);
    send(1'b0, 8'h11, 32'h0, 32'h0, 1'b1);
    send(1'b0, 8'h05, 32'h0, 32'h0, 1'b1);
    chk("midop_state_wait", {62'd0, state_dbg}, 64'd2);
    #3 rst = 1'b1;
    #1 chk("midop_busy_in_reset", {63'd0, busy}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    oram_stall = 1'b0;
    seen_ir = 0;
    seen_rv = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (input_ready) seen_ir++;
      if (rsp_valid) seen_rv++;
    end
    chk("midop_no_issue", 64'(seen_ir), 64'd0);
    chk("midop_no_rsp", 64'(seen_rv), 64'd0);
    chk("midop_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("midop_busy", {63'd0, busy}, 64'd0);

    chk("end_exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("end_no_double_strobe", 64'(ir_double), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "global timeout");
  end

endmodule
